pc_sequencer: RTL and testbench

- Instruction-fetch and program-flow controller for the 14-bit program ROM (11-bit address space).
- Owns the program counter and an 8-level hardware return stack, and runs a two-phase FETCH/EXEC cycle.
- Decodes the flow-control opcodes GOTO, CALL, RETURN and RETLW itself.
- Accepts a skip request from the ALU/datapath for conditional-skip instructions, and hands each fetched instruction to the datapath with a one-cycle execute strobe.

---
 rtl/pc_sequencer.sv | 83 ++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: two-phase fetch/exec program counter with an 8-level circular return stack.
module pc_sequencer #(
  parameter int PC_WIDTH    = 11,
  parameter int INSTR_WIDTH = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    Rom_addr_out,
  input  logic [INSTR_WIDTH-1:0] Rom_data_in,
  input  logic                   stall,
  input  logic                   skip_req,
  output logic [INSTR_WIDTH-1:0] ir_out,
  output logic                   exec_valid,
  output logic                   retlw_valid,
  output logic                   stk_ovf,
  output logic                   stk_unf
);
  localparam int SW = $clog2(STACK_DEPTH);
  localparam logic [SW:0] FULL = (SW+1)'(STACK_DEPTH);
  localparam logic [0:0] FETCH = 1'b0, EXEC = 1'b1;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [0:0]             r_state;
  logic [SW-1:0]          r_ptr;
  logic [SW:0]            r_cnt;
  logic                   r_ovf, r_unf;
  logic [PC_WIDTH-1:0]    r_stack [STACK_DEPTH];
  logic w_exec, w_goto, w_call, w_ret, w_retlw, w_push, w_pop;
  logic [PC_WIDTH-1:0] w_pc_inc, w_pc_next;
  logic [SW-1:0]       w_ptr_dec;
  assign w_exec    = r_state == EXEC;
  assign w_goto    = r_ir[13:11] == 3'b101;
  assign w_call    = r_ir[13:11] == 3'b100;
  assign w_ret     = r_ir == INSTR_WIDTH'(14'h0008);
  assign w_retlw   = r_ir[13:10] == 4'b1101;
  assign w_push    = w_exec && w_call;
  assign w_pop     = w_exec && (w_ret || w_retlw);
  assign w_pc_inc  = r_pc + PC_WIDTH'(1);
  assign w_ptr_dec = r_ptr - SW'(1);
  // flow-control opcodes take priority; skip only applies to ordinary instructions
  always_comb begin
    w_pc_next = !w_exec            ? w_pc_inc :
                (w_goto || w_call) ? r_ir[PC_WIDTH-1:0] :
                w_pop              ? r_stack[w_ptr_dec] :
                skip_req           ? w_pc_inc : r_pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_state <= FETCH;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_pc_next;
      r_state <= w_exec ? FETCH : EXEC;
      if (!w_exec) r_ir <= Rom_data_in;
      if (w_push) begin
        r_ptr <= r_ptr + SW'(1);
        r_cnt <= (r_cnt == FULL) ? r_cnt : r_cnt + (SW+1)'(1);
        if (r_cnt == FULL) r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_ptr <= w_ptr_dec;
        r_cnt <= (r_cnt == '0) ? r_cnt : r_cnt - (SW+1)'(1);
        if (r_cnt == '0) r_unf <= 1'b1;
      end
    end
  end
  // stack storage needs no reset; a full push simply overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push) r_stack[r_ptr] <= r_pc;
  end
  assign Rom_addr_out = r_pc;
  assign ir_out       = r_ir;
  assign exec_valid   = w_exec;
  assign retlw_valid  = w_exec && w_retlw;
  assign stk_ovf      = r_ovf;
  assign stk_unf      = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed program runs against a bench-held ROM with hand-computed addresses.
module tb_pc_sequencer;
  logic        clk = 0;
  logic        reset, stall, skip_req;
  logic [10:0] rom_addr;
  logic [13:0] rom_data, ir_out;
  logic        exec_valid, retlw_valid, stk_ovf, stk_unf;
  logic [13:0] rom [2048];
  int n_chk = 0, n_pass = 0;
  assign rom_data = rom[rom_addr];
  pc_sequencer dut (
    .clk(clk), .reset(reset), .Rom_addr_out(rom_addr), .Rom_data_in(rom_data),
    .stall(stall), .skip_req(skip_req), .ir_out(ir_out), .exec_valid(exec_valid),
    .retlw_valid(retlw_valid), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask
  task automatic do_reset();
    reset = 1; stall = 0; skip_req = 0;
    cyc(); cyc();
    reset = 0;
  endtask
  task automatic wait_fetch(input string tag, input logic [10:0] a);
    logic found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!exec_valid && rom_addr == a) found = 1;
      else cyc();
    end
    check(tag, found, 1);
  endtask
  logic [10:0] fseq [11] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd4, 11'd5, 11'd6, 11'd4};
  logic [10:0] ca [10];
  initial begin
    reset = 1; stall = 0; skip_req = 0;
    // straight-line code with GOTO 4 at address 6
    clear_rom();
    rom[0] = 14'h3003; rom[1] = 14'h00A5; rom[2] = 14'h0123; rom[3] = 14'h0234;
    rom[4] = 14'h0345; rom[5] = 14'h0456; rom[6] = 14'h2804;
    do_reset();
    check("rst_pc", rom_addr, 0);
    check("rst_exec", exec_valid, 0);
    check("rst_ir", ir_out, 0);
    check("rst_flags", {stk_ovf, stk_unf, retlw_valid}, 0);
    check("rst_cnt", dut.r_cnt, 0);
    for (int j = 0; j < 11; j++) begin
      check("seq_fetch_addr", rom_addr, fseq[j]);
      check("seq_fetch_exec", exec_valid, 0);
      cyc();
      check("seq_exec_addr", rom_addr, fseq[j] + 11'd1);
      check("seq_exec_v", exec_valid, 1);
      check("seq_exec_ir", ir_out, rom[fseq[j]]);
      cyc();
    end
    // CALL 0x100 at 0x010, RETURN at 0x100
    clear_rom();
    rom[0] = 14'h2810; rom[11'h010] = 14'h2100; rom[11'h100] = 14'h0008;
    do_reset();
    wait_fetch("call_reach", 11'h010);
    cyc(); cyc();
    check("call_target", rom_addr, 11'h100);
    check("call_cnt", dut.r_cnt, 1);
    cyc(); cyc();
    check("ret_addr", rom_addr, 11'h011);
    check("ret_cnt", dut.r_cnt, 0);
    check("ret_flags", {stk_ovf, stk_unf}, 0);
    // nine nested calls then returns
    clear_rom();
    for (int k = 0; k < 10; k++) ca[k] = 11'(k * 11'h040);
    for (int k = 0; k < 9; k++) begin
      rom[ca[k]] = 14'h2000 | 14'(ca[k+1]);
      rom[ca[k] + 11'd1] = 14'h0008;
    end
    rom[ca[9]] = 14'h0008;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cyc(); cyc();
      check("nest_call_addr", rom_addr, ca[k+1]);
      check("nest_ovf", stk_ovf, (k == 8) ? 1 : 0);
    end
    for (int r = 1; r <= 9; r++) begin
      cyc(); cyc();
      check("nest_ret_addr", rom_addr, (r <= 8) ? ca[9-r] + 11'd1 : ca[8] + 11'd1);
      check("nest_unf", stk_unf, (r == 9) ? 1 : 0);
    end
    // skip on plain instruction, ignored on GOTO
    clear_rom();
    rom[0] = 14'h2820; rom[11'h022] = 14'h2850;
    do_reset();
    wait_fetch("skip_reach", 11'h020);
    cyc();
    skip_req = 1;
    cyc();
    check("skip_fetch", rom_addr, 11'h022);
    cyc();
    check("skip_ign_fetch", rom_addr, 11'h023);
    cyc();
    check("skip_goto", rom_addr, 11'h050);
    skip_req = 0;
    // RETLW after CALL
    clear_rom();
    rom[0] = 14'h2030; rom[11'h030] = 14'h34A5;
    do_reset();
    cyc(); cyc();
    check("retlw_pre", retlw_valid, 0);
    cyc();
    check("retlw_v", retlw_valid, 1);
    check("retlw_k", ir_out[7:0], 8'hA5);
    cyc();
    check("retlw_ret", rom_addr, 11'h001);
    check("retlw_off", retlw_valid, 0);
    cyc();
    check("retlw_nop", retlw_valid, 0);
    // stall mid-EXEC, then stall+reset
    clear_rom();
    rom[0] = 14'h0123;
    do_reset();
    cyc();
    stall = 1; skip_req = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_addr", rom_addr, 1);
      check("stall_ir", ir_out, 14'h0123);
      check("stall_exec", exec_valid, 1);
    end
    stall = 0; skip_req = 0;
    cyc();
    check("unstall_addr", rom_addr, 1);
    check("unstall_exec", exec_valid, 0);
    stall = 1; reset = 1;
    cyc();
    reset = 0; stall = 0;
    check("stallrst_addr", rom_addr, 0);
    // reset during CALL EXEC
    clear_rom();
    rom[0] = 14'h2040;
    do_reset();
    cyc();
    check("rcall_exec", exec_valid, 1);
    reset = 1;
    cyc();
    reset = 0;
    check("rcall_pc", rom_addr, 0);
    check("rcall_state", exec_valid, 0);
    check("rcall_cnt", dut.r_cnt, 0);
    check("rcall_flags", {stk_ovf, stk_unf}, 0);
    // wrap from 0x7FF
    clear_rom();
    rom[0] = 14'h2FFF;
    do_reset();
    wait_fetch("wrap_reach", 11'h7FF);
    cyc();
    check("wrap_exec_addr", rom_addr, 0);
    cyc();
    check("wrap_fetch_addr", rom_addr, 0);
    check("wrap_fetch_exec", exec_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
